bit_serial_tx: RTL and testbench

- Parallel-to-serial word transmitter and bit-clock master for the SHA-256 bit-serial datapath.
- Accepts parallel words over a valid/ready handshake and generates the shared bclk and bit-index counter.
- Plays each word MSB-first on a single serial line, which feeds the serial-in ports of the downstream bit-serial stages (rotr, adders, shifters).
- Defines the producer side of the bus: data and counter change only when bclk falls, and are stable when bclk rises, which is where receivers record.

---
 rtl/bit_serial_tx.sv | 143 ++++++++++++++
 tb/tb_bit_serial_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_tx.sv
// Parallel-to-serial word transmitter and bit-clock master for the bit-serial datapath.
// Words play MSB-first; out/counter change only when bclk falls so receivers sample on the rise.
module bit_serial_tx #(
  parameter int unsigned W_WORD = 32,
  parameter int unsigned HALF   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [W_WORD-1:0]         word_in,
  input  logic                      word_valid,
  output logic                      word_ready,
  output logic                      bclk,
  output logic [$clog2(W_WORD)-1:0] counter,
  output logic                      out,
  output logic                      busy,
  output logic                      word_done
);

  localparam int unsigned CW = $clog2(W_WORD);
  localparam int unsigned PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned SW = W_WORD - 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W_WORD - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;

  logic [1:0]    state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [CW-1:0] counter_n;
  // Holds the bits still to be played; the bit on out is kept separately in out.
  logic [SW-1:0] shreg, shreg_n;
  logic          bclk_n, out_n, busy_n, word_done_n;
  logic          accept;

  assign word_ready = (state == IDLE) ||
                      ((state == HIGH) && (counter == CNT_LAST) && (phase == PH_LAST));
  assign accept     = word_valid && word_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    counter_n   = counter;
    shreg_n     = shreg;
    bclk_n      = bclk;
    out_n       = out;
    busy_n      = busy;
    word_done_n = 1'b0;

    case (state)
      IDLE: begin
        bclk_n    = 1'b0;
        out_n     = 1'b0;
        counter_n = '0;
        busy_n    = 1'b0;
        if (accept) begin
          shreg_n   = word_in[SW-1:0];
          out_n     = word_in[W_WORD-1];
          counter_n = '0;
          phase_n   = '0;
          busy_n    = 1'b1;
          state_n   = LOW;
        end
      end

      LOW: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          bclk_n  = 1'b1;
          state_n = HIGH;
        end else begin
          phase_n = phase + PW'(1);
        end
      end

      HIGH: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          bclk_n  = 1'b0;
          if (counter != CNT_LAST) begin
            out_n     = shreg[SW-1];
            shreg_n   = shreg << 1;
            counter_n = counter + CW'(1);
            state_n   = LOW;
          end else begin
            word_done_n = 1'b1;
            // A word waiting in the final cycle starts with no bclk gap.
            if (accept) begin
              shreg_n   = word_in[SW-1:0];
              out_n     = word_in[W_WORD-1];
              counter_n = '0;
              busy_n    = 1'b1;
              state_n   = LOW;
            end else begin
              out_n     = 1'b0;
              counter_n = '0;
              busy_n    = 1'b0;
              state_n   = IDLE;
            end
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end

      default: begin
        bclk_n    = 1'b0;
        out_n     = 1'b0;
        counter_n = '0;
        busy_n    = 1'b0;
        phase_n   = '0;
        state_n   = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      counter   <= '0;
      shreg     <= '0;
      bclk      <= 1'b0;
      out       <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      counter   <= counter_n;
      shreg     <= shreg_n;
      bclk      <= bclk_n;
      out       <= out_n;
      busy      <= busy_n;
      word_done <= word_done_n;
    end
  end

endmodule

// File: tb/tb_bit_serial_tx.sv
// Self-checking bench for bit_serial_tx: cycle-level timing model computed from
// accept time and word value, plus a bclk-driven rotating receiver for loopback.
module tb_bit_serial_tx;

  localparam int unsigned W        = 32;
  localparam int unsigned H        = 2;
  localparam int unsigned CW       = $clog2(W);
  localparam int          BIT      = 2 * H;
  localparam int          WORD_CYC = 2 * H * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  word_in;
  logic          word_valid;
  logic          word_ready;
  logic          bclk;
  logic [CW-1:0] counter;
  logic          out;
  logic          busy;
  logic          word_done;

  bit_serial_tx #(.W_WORD(W), .HALF(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .bclk       (bclk),
    .counter    (counter),
    .out        (out),
    .busy       (busy),
    .word_done  (word_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position within the word is just edges elapsed since accept.
  bit        m_active = 1'b0;
  int        m_d      = 0;
  logic [W-1:0] m_word = '0;
  bit        m_done   = 1'b0;
  bit        m_acc    = 1'b0;
  int        cyc      = 0;
  int        last_acc = 0;
  int        acc_gap  = 0;

  function automatic bit m_ready();
    return !m_active || (m_d == WORD_CYC - 1);
  endfunction

  task automatic check_outputs();
    logic [31:0] e_bclk, e_cnt, e_out, e_busy;
    int k, pos;
    e_bclk = 0; e_cnt = 0; e_out = 0; e_busy = 0;
    if (m_active) begin
      k      = m_d / BIT;
      pos    = m_d % BIT;
      e_bclk = (pos >= H) ? 32'd1 : 32'd0;
      e_cnt  = 32'(k);
      e_out  = 32'(m_word[W-1-k]);
      e_busy = 1;
    end
    check("bclk", 32'(bclk), e_bclk);
    check("counter", 32'(counter), e_cnt);
    check("out", 32'(out), e_out);
    check("busy", 32'(busy), e_busy);
    check("word_done", 32'(word_done), 32'(m_done));
    check("word_ready", 32'(word_ready), 32'(m_ready()));
  endtask

  // One clock: decide accept from pre-edge inputs, advance model, compare after the edge.
  task automatic step();
    bit acc;
    logic [W-1:0] w_s;
    acc = !rst && word_valid && m_ready();
    w_s = word_in;
    @(posedge clk);
    #1;
    cyc++;
    m_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_d      = 0;
      acc      = 1'b0;
    end else begin
      m_done = m_active && (m_d == WORD_CYC - 1);
      if (acc) begin
        m_active = 1'b1;
        m_d      = 0;
        m_word   = w_s;
      end else if (m_active) begin
        if (m_d == WORD_CYC - 1) m_active = 1'b0;
        else m_d++;
      end
    end
    m_acc = acc;
    if (acc) begin
      acc_gap  = cyc - last_acc;
      last_acc = cyc;
    end
    check_outputs();
  endtask

  task automatic idle(input int n);
    word_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      word_in = $urandom;
      step();
    end
  endtask

  task automatic send(input logic [W-1:0] w);
    int n;
    word_valid = 1'b1;
    word_in    = w;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_acc && n < 400);
    if (!m_acc) check("accept_timeout", 32'd0, 32'd1);
    word_valid = 1'b0;
  endtask

  // Downstream receiver: records on bclk rise (seen one clk late), rotating by rot.
  logic         bclk_prev = 1'b0;
  logic [W-1:0] rx0 = '0;
  logic [W-1:0] rx8 = '0;
  always @(posedge clk) begin
    bclk_prev <= bclk;
    if (bclk && !bclk_prev) begin
      rx0[W-1-int'(counter)]             <= out;
      rx8[W-1-((int'(counter) + 8) % W)] <= out;
    end
  end

  task automatic check_rx(input logic [W-1:0] w);
    logic [W-1:0] rot8;
    rot8 = (w >> 8) | (w << (W - 8));
    check("rx_rot0", rx0, w);
    check("rx_rot8", rx8, rot8);
  endtask

  initial begin
    int n;
    logic [W-1:0] w;
    rst        = 1'b1;
    word_valid = 1'b0;
    word_in    = '0;

    repeat (3) step();
    rst = 1'b0;
    step();

    // Single word with both end bits set.
    send(32'h8000_0001);
    idle(WORD_CYC + 8);
    check_rx(32'h8000_0001);

    // Back-to-back words, second taken on the word_done edge.
    send(32'hFFFF_FFFF);
    send(32'h0000_0000);
    check("b2b_gap", 32'(acc_gap), 32'(WORD_CYC));
    check("b2b_done_edge", 32'(word_done), 32'd1);
    idle(WORD_CYC + 8);
    check_rx(32'h0000_0000);

    // Backpressure: word_in toggles while not ready; A5A5A5A5 presented when ready.
    send($urandom);
    idle(40);
    word_valid = 1'b1;
    n = 0;
    do begin
      word_in = m_ready() ? 32'hA5A5_A5A5 : $urandom;
      step();
      n++;
    end while (!m_acc && n < 400);
    if (!m_acc) check("bp_timeout", 32'd0, 32'd1);
    word_valid = 1'b0;
    for (int i = 0; i < WORD_CYC + 8; i++) begin
      word_in = $urandom;
      step();
    end
    check_rx(32'hA5A5_A5A5);

    // Asynchronous reset at bit 13.
    send(32'hDEAD_BEEF);
    n = 0;
    while (!(m_active && (m_d / BIT) == 13) && n < 200) begin
      step();
      n++;
    end
    check("reach_bit13", 32'(counter), 32'd13);
    rst = 1'b1;
    m_active = 1'b0;
    m_d      = 0;
    m_done   = 1'b0;
    #1;
    check_outputs();
    step();
    step();
    rst = 1'b0;
    idle(WORD_CYC + 4);
    send(32'h1234_5678);
    idle(WORD_CYC + 4);
    check_rx(32'h1234_5678);

    // Random words with mixed back-to-back and idle gaps.
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      send(w);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 150));
    end
    idle(WORD_CYC + 8);
    check_rx(m_word);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
